// File: rtl/sci_pkg.sv
// Shared SCI definitions: state encoding, default baud divisor and logb2 helper.
// The PARITY state exists only when SCI_TX_PARITY_EN is defined.
package sci_pkg;

  localparam int unsigned BaudDivDefault = 434;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StData,
`ifdef SCI_TX_PARITY_EN
    StParity,
`endif
    StStop
  } sci_state_e;

  // Bits needed to hold values 0..n-1 (ceil(log2(n))), never less than 1.
  function automatic int unsigned logb2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sci_baud_gen.sv
// Bit-period counter running 0..BAUD_DIV-1 with a bit_end strobe on the terminal count.
// A synchronous clear holds the counter at zero between frames.
module sci_baud_gen
  import sci_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int unsigned CntW = logb2(BAUD_DIV);
  localparam logic [CntW-1:0] TermCnt = CntW'(BAUD_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end_o = (cnt_q == TermCnt);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || bit_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sci_tx.sv
// SCI transmitter: pulls bytes from a buffer FIFO and sends 8N1-style frames, LSB first.
// Define SCI_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module sci_tx
  import sci_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault,
  parameter int unsigned WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_load,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_valid,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int unsigned IdxW = logb2(WIDTH) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  sci_state_e       state_q;
  logic             tx_q;
  logic             tx_done_q;
  logic [WIDTH-1:0] shift_q;
  logic [IdxW-1:0]  idx_q;
`ifdef SCI_TX_PARITY_EN
  logic             parity_q;
`endif
  logic             bit_end;
  logic             baud_clr;

  // The bit timer only runs while a bit is on the line.
  assign baud_clr = (state_q == StIdle) || (state_q == StFetch);

  sci_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (baud_clr),
    .bit_end_o (bit_end)
  );

  // Load is decoded from the registered state so the FIFO sees it during the IDLE cycle.
  assign fifo_load = rst_n && (state_q == StIdle) && !fifo_empty;
  assign busy      = (state_q != StIdle);
  assign tx        = tx_q;
  assign tx_done   = tx_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
      shift_q   <= '0;
      idx_q     <= '0;
`ifdef SCI_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) state_q <= StFetch;
        end
        StFetch: begin
          if (fifo_valid) begin
            shift_q <= fifo_dout;
            idx_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= StStart;
`ifdef SCI_TX_PARITY_EN
            parity_q <= ^fifo_dout;
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StStart: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= StData;
          end
        end
        StData: begin
          if (bit_end) begin
            if (idx_q == LastIdx) begin
              idx_q <= '0;
`ifdef SCI_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= StParity;
`else
              tx_q    <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              idx_q   <= idx_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
`ifdef SCI_TX_PARITY_EN
        StParity: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          if (bit_end) begin
            tx_done_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
